// File: rtl/caesar_pkg.sv
// Shared Caesar definitions: alphabet and bus widths, FSM encoding, buffer entry
// layout and the mod-ALPHA subtract used by the decrypt path.
package caesar_pkg;

    localparam int ALPHA = 26;
    localparam int SYM_W = 6;
    localparam int KEY_W = 5;
    localparam int CNT_W = 8;

    localparam logic [SYM_W-1:0] ALPHA_S = SYM_W'(ALPHA);
    localparam logic [KEY_W-1:0] ALPHA_K = KEY_W'(ALPHA);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [SYM_W-1:0] sym;
        logic             last;
        logic             err;
    } sym_ent_t;

    // Both operands must already be below ALPHA; c + ALPHA - k never exceeds 2*ALPHA-1.
    function automatic logic [SYM_W-1:0] caesar_sub(input logic [SYM_W-1:0] c,
                                                    input logic [KEY_W-1:0] k);
        logic [SYM_W-1:0] kk;
        kk = {{(SYM_W-KEY_W){1'b0}}, k};
        if (c >= kk) begin
            return c - kk;
        end
        return c + ALPHA_S - kk;
    endfunction

endpackage

// File: rtl/caesar_out_fifo.sv
// 2-entry output buffer; head entry drives the outputs straight from a register.
// Latency: push into an empty buffer is visible on out_dat_o the next cycle.
// Backpressure: full_o at two entries; the caller must not push while full_o is high.
module caesar_out_fifo #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         out_rdy_i,
    output logic         out_vld_o,
    output logic [W-1:0] out_dat_o,
    output logic         full_o
);

    logic [1:0]   cnt_q, cnt_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic         pop;

    assign out_vld_o = (cnt_q != 2'd0);
    assign full_o    = (cnt_q == 2'd2);
    assign out_dat_o = head_q;
    assign pop       = out_vld_o && out_rdy_i;

    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        case ({push_i, pop})
            2'b10: begin
                if (cnt_q == 2'd0) head_d = push_dat_i;
                else               tail_d = push_dat_i;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                // Simultaneous push/pop keeps the count; the older entry moves up first.
                if (cnt_q == 2'd1) begin
                    head_d = push_dat_i;
                end else begin
                    head_d = tail_q;
                    tail_d = push_dat_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

endmodule

// File: rtl/caesar_stream_decrypt.sv
// Streaming Caesar decryptor: key latched at message start, symbols decrypted on accept.
// Latency: accepted symbol appears on out_* one cycle later when the buffer is empty.
// Backpressure: in_ready drops while the 2-entry output buffer is full or outside RUN.
module caesar_stream_decrypt
    import caesar_pkg::*;
(
    input  logic             CLOCK_50,
    input  logic             rst,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_load,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SYM_W-1:0] in_sym,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SYM_W-1:0] out_sym,
    output logic             out_last,
    output logic             out_err,
    output logic             key_err,
    output logic             busy,
    output logic [CNT_W-1:0] sym_count
);

    state_t           state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             key_err_q, key_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic     accept;
    logic     pop;
    logic     fifo_full;
    logic     in_range;
    sym_ent_t push_ent;
    sym_ent_t head_ent;

    assign in_ready = (state_q == ST_RUN) && !fifo_full;
    assign accept   = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign in_range = (in_sym < ALPHA_S);

    // Out-of-range symbols pass through untouched and are flagged rather than dropped.
    assign push_ent.sym  = in_range ? caesar_sub(in_sym, key_q) : in_sym;
    assign push_ent.last = in_last;
    assign push_ent.err  = !in_range;

    caesar_out_fifo #(
        .W($bits(sym_ent_t))
    ) u_out_fifo (
        .clk_i      (CLOCK_50),
        .rst_ni     (rst),
        .push_i     (accept),
        .push_dat_i (push_ent),
        .out_rdy_i  (out_ready),
        .out_vld_o  (out_valid),
        .out_dat_o  (head_ent),
        .full_o     (fifo_full)
    );

    assign out_sym   = head_ent.sym;
    assign out_last  = head_ent.last;
    assign out_err   = head_ent.err;
    assign key_err   = key_err_q;
    assign busy      = (state_q != ST_IDLE);
    assign sym_count = cnt_q;

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        key_err_d = key_err_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (key_load) begin
                    if (key_in < ALPHA_K) begin
                        key_d     = key_in;
                        key_err_d = 1'b0;
                        cnt_d     = '0;
                        state_d   = ST_RUN;
                    end else begin
                        key_err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (accept && in_last) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (pop && head_ent.last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Accepts only happen in RUN, so this never collides with the IDLE clear.
        if (accept && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            key_q     <= '0;
            key_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            key_err_q <= key_err_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_caesar_stream_decrypt.sv
// Randomized and directed checks of caesar_stream_decrypt against a queue-based model.
module tb_caesar_stream_decrypt;

    logic       CLOCK_50;
    logic       rst;
    logic [4:0] key_in;
    logic       key_load;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] in_sym;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_sym;
    logic       out_last;
    logic       out_err;
    logic       key_err;
    logic       busy;
    logic [7:0] sym_count;

    typedef struct {
        int sym;
        bit last;
        bit err;
    } ent_t;

    localparam int P_IDLE  = 0;
    localparam int P_RUN   = 1;
    localparam int P_DRAIN = 2;

    ent_t m_q[$];
    int   m_phase;
    int   m_key;
    int   m_cnt;
    bit   m_kerr;
    bit   m_acc;

    int total;
    int bad;
    int msg[$];
    int got[$];
    int idx;
    bit hold;
    int t1e[4] = '{23, 24, 25, 22};
    int t2e[2] = '{7, 13};
    int t4e[4] = '{2, 3, 4, 5};
    int t5e[2] = '{30, 0};

    caesar_stream_decrypt dut (
        .CLOCK_50  (CLOCK_50),
        .rst       (rst),
        .key_in    (key_in),
        .key_load  (key_load),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sym    (in_sym),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sym   (out_sym),
        .out_last  (out_last),
        .out_err   (out_err),
        .key_err   (key_err),
        .busy      (busy),
        .sym_count (sym_count)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic int dec(input int c, input int k);
        return (c >= 26) ? c : (c + 26 - k) % 26;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_out_sym"},   32'(out_sym),   0);
        chk({tag, "_out_last"},  32'(out_last),  0);
        chk({tag, "_out_err"},   32'(out_err),   0);
        chk({tag, "_key_err"},   32'(key_err),   0);
        chk({tag, "_busy"},      32'(busy),      0);
        chk({tag, "_sym_count"}, 32'(sym_count), 0);
        chk({tag, "_in_ready"},  32'(in_ready),  0);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_phase = P_IDLE;
        m_key   = 0;
        m_cnt   = 0;
        m_kerr  = 0;
    endtask

    // One clock: compare DUT against the model, advance the clock, advance the model.
    task automatic tick();
        bit   exp_rdy, acc, pop, plast, l, kl;
        int   c, kv;
        ent_t e;
        exp_rdy = (m_phase == P_RUN) && (m_q.size() < 2);
        chk("in_ready",  32'(in_ready),  32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            chk("out_sym",  32'(out_sym),  m_q[0].sym);
            chk("out_last", 32'(out_last), 32'(m_q[0].last));
            chk("out_err",  32'(out_err),  32'(m_q[0].err));
        end
        chk("busy",      32'(busy),      32'(m_phase != P_IDLE));
        chk("key_err",   32'(key_err),   32'(m_kerr));
        chk("sym_count", 32'(sym_count), m_cnt);
        acc = in_valid && exp_rdy;
        pop = (m_q.size() != 0) && out_ready;
        c   = int'(in_sym);
        l   = in_last;
        kl  = key_load;
        kv  = int'(key_in);
        if (pop) got.push_back(int'(out_sym));
        @(posedge CLOCK_50);
        #1;
        plast = 0;
        if (pop) begin
            e     = m_q.pop_front();
            plast = e.last;
        end
        if (acc) begin
            m_q.push_back('{sym: dec(c, m_key), last: l, err: (c >= 26)});
            if (m_cnt < 255) m_cnt++;
        end
        case (m_phase)
            P_IDLE: begin
                if (kl) begin
                    if (kv < 26) begin
                        m_key   = kv;
                        m_kerr  = 0;
                        m_cnt   = 0;
                        m_phase = P_RUN;
                    end else begin
                        m_kerr = 1;
                    end
                end
            end
            P_RUN:   if (acc && l) m_phase = P_DRAIN;
            P_DRAIN: if (pop && plast) m_phase = P_IDLE;
            default: ;
        endcase
        m_acc = acc;
    endtask

    task automatic new_msg();
        msg.delete();
        got.delete();
        idx  = 0;
        hold = 0;
    endtask

    task automatic load(input int k);
        key_in   = 5'(k);
        key_load = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        key_load = 1'b0;
    endtask

    // Stream msg[idx..] with random valid/ready; key_load noise must be ignored outside IDLE.
    task automatic drive(input int pv, input int pr, input int ncyc, input bit until_idle);
        int n;
        n = 0;
        while (n < ncyc && !(until_idle && m_phase == P_IDLE)) begin
            if (idx < msg.size() && !hold) hold = ($urandom_range(99) < pv);
            in_valid  = hold;
            in_sym    = (idx < msg.size()) ? 6'(msg[idx]) : 6'd0;
            in_last   = (idx == msg.size() - 1);
            out_ready = ($urandom_range(99) < pr);
            key_load  = ($urandom_range(7) == 0);
            key_in    = 5'($urandom_range(31));
            tick();
            if (m_acc) begin
                idx++;
                hold = 0;
            end
            n++;
        end
        key_load  = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (until_idle) chk("drain_done_busy", 32'(busy), 0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        key_load = 1'b0;
        key_in   = '0;
        in_valid = 1'b0;
        in_sym   = '0;
        in_last  = 1'b0;
        out_ready = 1'b0;
        model_reset();
        new_msg();
        #2;
        check_all_zero("por");
        @(negedge CLOCK_50);
        rst = 1'b1;
        @(posedge CLOCK_50);
        #1;

        // key 3: 0,1,2,25 -> 23,24,25,22
        new_msg();
        msg = '{0, 1, 2, 25};
        load(3);
        drive(100, 100, 200, 1);
        chk("t1_count", 32'(sym_count), 4);
        chk("t1_n", 32'(got.size()), 4);
        for (int i = 0; i < 4; i++) if (i < got.size()) chk("t1_sym", 32'(got[i]), t1e[i]);

        // key 0 is the identity
        new_msg();
        msg = '{7, 13};
        load(0);
        drive(100, 100, 200, 1);
        chk("t2_n", 32'(got.size()), 2);
        for (int i = 0; i < 2; i++) if (i < got.size()) chk("t2_sym", 32'(got[i]), t2e[i]);

        // illegal key rejected, then a good key starts a message
        load(27);
        chk("t3_key_err", 32'(key_err), 1);
        chk("t3_busy", 32'(busy), 0);
        chk("t3_in_ready", 32'(in_ready), 0);
        new_msg();
        msg = '{9};
        load(5);
        chk("t3_key_err_clr", 32'(key_err), 0);
        chk("t3_busy_run", 32'(busy), 1);
        drive(100, 100, 200, 1);

        // consumer stalled: only two symbols fit
        new_msg();
        msg = '{3, 4, 5, 6};
        load(1);
        drive(100, 0, 6, 0);
        chk("t4_accepted", 32'(sym_count), 2);
        chk("t4_in_ready", 32'(in_ready), 0);
        drive(100, 100, 200, 1);
        chk("t4_n", 32'(got.size()), 4);
        for (int i = 0; i < 4; i++) if (i < got.size()) chk("t4_sym", 32'(got[i]), t4e[i]);

        // out-of-range symbol passes through flagged, stream continues
        new_msg();
        msg = '{30, 4};
        load(4);
        drive(100, 100, 200, 1);
        chk("t5_n", 32'(got.size()), 2);
        for (int i = 0; i < 2; i++) if (i < got.size()) chk("t5_sym", 32'(got[i]), t5e[i]);

        // async reset with two entries buffered
        new_msg();
        msg = '{10, 11, 12};
        load(2);
        drive(100, 0, 4, 0);
        chk("t6_buffered", 32'(sym_count), 2);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("t6_rst");
        model_reset();
        new_msg();
        @(negedge CLOCK_50);
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_sym    = 6'd5;
        in_last   = 1'b0;
        out_ready = 1'b1;
        key_load  = 1'b0;
        repeat (3) tick();
        chk("t6_no_accept", 32'(sym_count), 0);
        in_valid = 1'b0;
        msg = '{5};
        load(7);
        drive(100, 100, 200, 1);

        // long message: counter saturates
        new_msg();
        for (int i = 0; i < 300; i++) msg.push_back(int'($urandom_range(25)));
        load(int'($urandom_range(25)));
        drive(100, 100, 1000, 1);
        chk("sat_count", 32'(sym_count), 255);

        // random messages with mixed throttling and occasional bad keys/symbols
        for (int m = 0; m < 15; m++) begin
            new_msg();
            for (int i = 0; i < int'($urandom_range(20, 1)); i++) begin
                if ($urandom_range(9) == 0) msg.push_back(int'($urandom_range(63, 26)));
                else                        msg.push_back(int'($urandom_range(25)));
            end
            if ($urandom_range(3) == 0) load(int'($urandom_range(31, 26)));
            load(int'($urandom_range(25)));
            drive(int'($urandom_range(100, 30)), int'($urandom_range(100, 20)), 3000, 1);
            chk("rnd_n", 32'(got.size()), 32'(msg.size()));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/caesar_stream_decrypt.md
Name: caesar_stream_decrypt

Overview:
Streaming Caesar decryptor and the receive-side counterpart of the board's Caesar encrypt/display path. It accepts 6-bit ciphertext symbols (0..25) over a valid/ready handshake and decrypts each with a key latched at message start. Plaintext leaves through a 2-entry output buffer with its own valid/ready handshake. It feeds the same binary_to_BCD / 7-seg display chain or a downstream consumer.

Parameters:
ALPHA, 26, alphabet size; legal symbols and keys are 0..ALPHA-1
SYM_W, 6, symbol width (matches existing 6-bit plaintext/cyphertext buses)
KEY_W, 5, key width (matches 5 key switches)
CNT_W, 8, width of the accepted-symbol counter

Ports:
CLOCK_50  in  1  system clock
rst  in  1  asynchronous, active-low reset
key_in  in  KEY_W  key value, sampled on key_load
key_load  in  1  latch key_in; honoured only in IDLE
in_valid  in  1  ciphertext symbol valid
in_ready  out  1  block can accept a symbol this cycle
in_sym  in  SYM_W  ciphertext symbol
in_last  in  1  marks final symbol of the message
out_valid  out  1  plaintext symbol available
out_ready  in  1  consumer accepts the symbol
out_sym  out  SYM_W  plaintext symbol
out_last  out  1  final symbol of the message
out_err  out  1  symbol was out of range (>= ALPHA)
key_err  out  1  last key_load carried key >= ALPHA (sticky)
busy  out  1  state != IDLE
sym_count  out  CNT_W  symbols accepted since last successful key_load

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE; key register 0; buffer empty.
  - out_valid, out_sym, out_last, out_err, key_err, busy, sym_count, in_ready all 0.
- FSM states are IDLE, RUN and DRAIN.
  - IDLE, key_load=1 with key_in < ALPHA: latch key, clear key_err and sym_count, go to RUN.
  - IDLE, key_load=1 with key_in >= ALPHA: set key_err=1, leave key and state unchanged.
  - RUN, accepted symbol with in_last=1: go to DRAIN.
  - DRAIN, buffer empties (pop of the entry with last=1): go to IDLE.
  - key_load in RUN or DRAIN is ignored; key_err does not change.
- in_ready = (state==RUN) && (buffer count < 2). It is 0 in IDLE and DRAIN. A symbol is accepted when in_valid && in_ready.
- Decrypt for c < ALPHA: p = (c >= k) ? c-k : c+ALPHA-k. Pure mod-ALPHA arithmetic with no wrap beyond ALPHA-1, and out_err=0.
- Decrypt for c >= ALPHA: entry stores p = c unchanged with out_err=1. The stream continues.
- Latency: a symbol accepted in cycle N appears on out_* in cycle N+1 when the buffer was empty. out_* is driven from registers only.
- Buffer: 2-entry FIFO of {sym, last, err}.
  - out_valid = count != 0. Pop on out_valid && out_ready.
  - Push and pop in the same cycle with count=1: count stays 1 and order is preserved.
  - At count=2 in_ready=0, so no push can occur.
- out_sym, out_last and out_err hold steady while out_valid && !out_ready.
- sym_count increments per accepted symbol and saturates at 2^CNT_W-1.
- busy = (state != IDLE).

Decomposition:
- Shared package caesar_pkg holds ALPHA, SYM_W, KEY_W and the FSM state encoding (IDLE/RUN/DRAIN). The encrypt path reuses these.
- One natural sub-module is caesar_out_fifo: the 2-entry {sym,last,err} buffer with valid/ready on the output side.
- The mod-ALPHA subtract is a function in caesar_pkg, not a module.

Test Plan:
- key_load key_in=3, stream 0,1,2,25 (last on 25), out_ready=1: out_sym 23,24,25,22; out_last only on 22; IDLE after pop; sym_count=4.
- key 0, stream 7,13 (last): out_sym 7,13 identical; each appears exactly 1 cycle after acceptance.
- key_load key_in=27 in IDLE: key_err=1, busy=0, in_ready=0; then key_load key_in=5: key_err=0, state RUN.
- key 1, out_ready=0 for 6 cycles with in_valid held high: exactly 2 symbols accepted, then in_ready=0; on release both come out in order with no loss or duplication.
- key 4, in_sym=30: out_sym=30 with out_err=1; next symbol 4 gives 0 with out_err=0.
- rst asserted low mid-RUN with 2 entries buffered: all outputs 0 immediately; after release, state IDLE, key_load required before any symbol is accepted.
